// File: rtl/ser_par_lane_if.sv
// Lane-side signal bundle: serial bit in, aligned byte/strobe/valid/active out.
// master is the receiver that drives the byte outputs; slave is the lane source and consumer.
interface ser_par_lane_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );

  modport slave (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );
endinterface

// File: rtl/ser_par_lane.sv
// Serial-to-parallel lane receiver: comma hunt, byte alignment, activation after ACTIVE_COUNT commas.
// Outputs registered on the edge sampling a byte's last bit (MSB-at-N -> visible after N+7); no backpressure.
module ser_par_lane #(
  parameter logic [7:0] COMMA        = 8'hBC,
  parameter int         ACTIVE_COUNT = 4
) (
  input  logic            clk_32f,
  input  logic            reset,
  ser_par_lane_if.master  lane
);

  typedef enum logic [1:0] {HUNT, SYNC, ACTIVE} state_t;

  localparam logic [3:0] ACT_CNT = 4'(ACTIVE_COUNT);

  state_t     state;
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] comma_cnt;
  logic [7:0] data_q;
  logic       valid_q;
  logic       strobe_q;
  logic       active_q;

  logic [7:0] cand;
  logic       is_comma;
  logic       byte_done;

  // The candidate includes the bit being sampled, so decisions land on the last-bit edge.
  assign cand      = {sr, lane.data_in};
  assign is_comma  = (cand == COMMA);
  assign byte_done = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      sr        <= 7'd0;
      bit_cnt   <= 3'd0;
      comma_cnt <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr       <= cand[6:0];
      strobe_q <= 1'b0;
      valid_q  <= 1'b0;
      case (state)
        HUNT: begin
          if (is_comma) begin
            state     <= SYNC;
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd1;
          end
        end
        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            strobe_q <= 1'b1;
            if (is_comma) begin
              comma_cnt <= comma_cnt + 4'd1;
              if (comma_cnt + 4'd1 == ACT_CNT) begin
                state    <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              // A false bit-level lock lands here on the first misaligned byte.
              state     <= HUNT;
              comma_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            strobe_q <= 1'b1;
            if (!is_comma) begin
              valid_q <= 1'b1;
              data_q  <= cand;
            end
          end
        end
        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = active_q;

  a_valid_needs_strobe : assert property (@(posedge clk_32f) disable iff (!reset)
    valid_q |-> strobe_q);
  a_valid_needs_active : assert property (@(posedge clk_32f) disable iff (!reset)
    valid_q |-> active_q);
  a_strobe_single : assert property (@(posedge clk_32f) disable iff (!reset)
    strobe_q |=> !strobe_q);

endmodule

// File: tb/tb_ser_par_lane.sv
// Directed-vector bench for ser_par_lane: expected strobes queued at stimulus time, checked by a monitor.
module tb_ser_par_lane;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ser_par_lane_if l0 ();
  ser_par_lane_if l1 ();

  ser_par_lane dut (
    .clk_32f (clk),
    .reset   (rst_n),
    .lane    (l0.master)
  );

  ser_par_lane #(.ACTIVE_COUNT(2)) dut2 (
    .clk_32f (clk),
    .reset   (rst_n),
    .lane    (l1.master)
  );

  typedef struct {
    int         cyc;
    logic       vld;
    logic [7:0] dat;
    logic       act;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic lane_check(input int ln, input logic stb, input logic vld,
                            input logic [7:0] dat, input logic act);
    exp_t e;
    int   depth;
    check($sformatf("l%0d valid_without_strobe", ln), 32'(vld & ~stb), 32'd0);
    if (stb) begin
      depth = (ln == 0) ? q0.size() : q1.size();
      tests++;
      if (depth == 0) begin
        fails++;
        $display("FAIL l%0d unexpected_strobe: got strobe at cycle %0d, required none", ln, cyc);
      end else begin
        e = (ln == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("l%0d strobe_cycle", ln), 32'(cyc), 32'(e.cyc));
        check($sformatf("l%0d valid_out", ln), 32'(vld), 32'(e.vld));
        check($sformatf("l%0d data_out", ln), 32'(dat), 32'(e.dat));
        check($sformatf("l%0d active", ln), 32'(act), 32'(e.act));
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    lane_check(0, l0.byte_strobe, l0.valid_out, l0.data_out, l0.active);
    lane_check(1, l1.byte_strobe, l1.valid_out, l1.data_out, l1.active);
  end

  task automatic send_bit(input int ln, input logic b);
    @(negedge clk);
    if (ln == 0) l0.data_in = b;
    else         l1.data_in = b;
  endtask

  // Expected strobe lands on the edge that samples bit 0, i.e. 8 edges after the MSB is driven.
  task automatic send_byte(input int ln, input logic [7:0] b, input bit stb,
                           input logic vld, input logic [7:0] dat, input logic act);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      send_bit(ln, b[i]);
      if (i == 7 && stb) begin
        e.cyc = cyc + 8;
        e.vld = vld;
        e.dat = dat;
        e.act = act;
        if (ln == 0) q0.push_back(e);
        else         q1.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    l0.data_in = 1'b0;
    l1.data_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    l0.data_in = 1'b0;
    l1.data_in = 1'b0;

    // Reset held with random line activity
    repeat (20) begin
      @(negedge clk);
      l0.data_in = 1'($urandom_range(0, 1));
    end
    check("rst data_out", 32'(l0.data_out), 32'h00);
    check("rst valid_out", 32'(l0.valid_out), 32'd0);
    check("rst byte_strobe", 32'(l0.byte_strobe), 32'd0);
    check("rst active", 32'(l0.active), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    l0.data_in = 1'b0;
    repeat (64) @(negedge clk);
    check("idle active", 32'(l0.active), 32'd0);
    check("idle data_out", 32'(l0.data_out), 32'h00);

    // Offset alignment: 3 junk bits then 4 commas and two data bytes
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_byte(0, 8'hBC, 0, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b1);
    send_byte(0, 8'hA5, 1, 1'b1, 8'hA5, 1'b1);
    send_byte(0, 8'h3C, 1, 1'b1, 8'h3C, 1'b1);
    do_reset();

    // Broken comma run, relock, then data
    send_byte(0, 8'hBC, 0, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'h12, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 0, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b1);
    send_byte(0, 8'h77, 1, 1'b1, 8'h77, 1'b1);

    // Idle comma inside an active data stream
    send_byte(0, 8'h55, 1, 1'b1, 8'h55, 1'b1);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h55, 1'b1);
    send_byte(0, 8'h66, 1, 1'b1, 8'h66, 1'b1);

    // Asynchronous reset three bits into a byte while active
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    @(posedge clk);
    #2;
    check("pre-reset active", 32'(l0.active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async data_out", 32'(l0.data_out), 32'h00);
    check("async valid_out", 32'(l0.valid_out), 32'd0);
    check("async byte_strobe", 32'(l0.byte_strobe), 32'd0);
    check("async active", 32'(l0.active), 32'd0);
    @(negedge clk);
    l0.data_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(0, 8'hBC, 0, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b0);
    send_byte(0, 8'hBC, 1, 1'b0, 8'h00, 1'b1);
    send_byte(0, 8'h9A, 1, 1'b1, 8'h9A, 1'b1);
    do_reset();

    // ACTIVE_COUNT = 2 instance
    send_byte(1, 8'hBC, 0, 1'b0, 8'h00, 1'b0);
    send_byte(1, 8'hBC, 1, 1'b0, 8'h00, 1'b1);
    send_byte(1, 8'h5A, 1, 1'b1, 8'h5A, 1'b1);
    do_reset();

    repeat (16) @(negedge clk);
    check("l0 pending expectations", 32'(q0.size()), 32'd0);
    check("l1 pending expectations", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
